// File: rtl/data_mem_unit.sv
// Byte-addressed 32-bit data memory: asynchronous read, synchronous write, async clear on reset.
// Define DATA_MEM_SUBWORD_EN to enable RV32I byte/halfword loads and stores via funct3.
module data_mem_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writedata,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [Depth];
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            byte_en;
    logic [31:0]           wdata;
    logic [31:0]           rword;
    logic [31:0]           rdata;

    assign idx   = ALUResult[ADDR_WIDTH+1:2];
    assign rword = mem_q[idx];

`ifdef DATA_MEM_SUBWORD_EN
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[8*ALUResult[1:0] +: 8];
    assign rhalf = ALUResult[1] ? rword[31:16] : rword[15:0];

    // Sub-word stores replicate the data so each lane carries it; byte_en picks the lane.
    always_comb begin
        byte_en = 4'hF;
        wdata   = writedata;
        unique case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << ALUResult[1:0];
                wdata   = {4{writedata[7:0]}};
            end
            2'b01: begin
                byte_en = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{writedata[15:0]}};
            end
            default: begin
                byte_en = 4'hF;
                wdata   = writedata;
            end
        endcase
    end

    always_comb begin
        rdata = rword;
        case (funct3)
            3'b000:  rdata = {{24{rbyte[7]}}, rbyte};
            3'b001:  rdata = {{16{rhalf[15]}}, rhalf};
            3'b100:  rdata = {24'h0, rbyte};
            3'b101:  rdata = {16'h0, rhalf};
            default: rdata = rword;
        endcase
    end

    logic unused_addr;
    assign unused_addr = ^ALUResult[31:ADDR_WIDTH+2];
`else
    assign byte_en = 4'hF;
    assign wdata   = writedata;
    assign rdata   = rword;

    logic unused_in;
    assign unused_in = ^{ALUResult[31:ADDR_WIDTH+2], ALUResult[1:0], funct3};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (MemWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign ReadData = reset ? 32'h0 : rdata;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit; sub-word checks apply when
// DATA_MEM_SUBWORD_EN is defined.
module tb_data_mem_unit;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] writedata;
    logic [2:0]  funct3;
    logic [31:0] ReadData;

    int passed = 0;
    int total  = 0;

    logic [31:0] rnd_addr [5];
    logic [31:0] rnd_data [5];

    data_mem_unit #(.ADDR_WIDTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .writedata (writedata),
        .funct3    (funct3),
        .ReadData  (ReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] exp);
        total++;
        assert (ReadData === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, ReadData, exp);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] f3,
                      input string tag, input logic [31:0] exp);
        ALUResult = addr;
        funct3    = f3;
        #1;
        check(tag, exp);
    endtask

    // Drives one store held for 'edges' rising edges, then drops MemWrite.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] f3, input int edges);
        ALUResult = addr;
        writedata = data;
        funct3    = f3;
        MemWrite  = 1'b1;
        repeat (edges) @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        writedata = 32'h0;
        funct3    = 3'b010;
        #15;
        reset = 1'b0;
        #1;

        rd(32'h000, 3'b010, "rst_0x000", 32'h0);
        rd(32'h3FC, 3'b010, "rst_0x3fc", 32'h0);
        rd(32'hFFC, 3'b010, "rst_0xffc", 32'h0);

        wr(32'h100, 32'hDEADBEEF, 3'b010, 1);
        check("wr_0x100", 32'hDEADBEEF);
        writedata = 32'h12345678;
        @(posedge clk);
        #1;
        check("nowr_hold", 32'hDEADBEEF);

        wr(32'h004, 32'hA5A5A5A5, 3'b010, 1);
        rd(32'h1004, 3'b010, "wrap_0x1004", 32'hA5A5A5A5);
        rd(32'h006,  3'b010, "misalign_w", 32'hA5A5A5A5);

        wr(32'h020, 32'h11223344, 3'b010, 1);
`ifdef DATA_MEM_SUBWORD_EN
        rd(32'h006, 3'b000, "lb_0x006", 32'hFFFFFFA5);
        wr(32'h021, 32'h000000FF, 3'b000, 1);
        rd(32'h020, 3'b010, "lw_after_sb", 32'h1122FF44);
        rd(32'h021, 3'b000, "lb_0x21", 32'hFFFFFFFF);
        rd(32'h021, 3'b100, "lbu_0x21", 32'h000000FF);
        rd(32'h022, 3'b101, "lhu_0x22", 32'h00001122);
        wr(32'h023, 32'h00008001, 3'b001, 1);
        rd(32'h022, 3'b001, "lh_after_sh", 32'hFFFF8001);
        rd(32'h020, 3'b010, "lw_after_sh", 32'h8001FF44);
`else
        rd(32'h006, 3'b000, "f3_ignored_rd", 32'hA5A5A5A5);
        wr(32'h021, 32'h000000FF, 3'b000, 1);
        rd(32'h020, 3'b010, "f3_ignored_wr", 32'h000000FF);
`endif

        // Clean slate so the scoreboard below starts from all-zero memory.
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        rd(32'h100, 3'b010, "rst_clears", 32'h0);

        for (int i = 0; i < 5; i++) begin
            logic [31:0] a;
            logic        dup;
            do begin
                a   = 32'($urandom_range(0, 255)) * 4;
                dup = (a == 32'h40);
                for (int j = 0; j < i; j++) if (rnd_addr[j] == a) dup = 1'b1;
            end while (dup);
            rnd_addr[i] = a;
            rnd_data[i] = $urandom;
            wr(rnd_addr[i], rnd_data[i], 3'b010, 2);
            #100;
        end
        for (int i = 0; i < 5; i++) begin
            rd(rnd_addr[i], 3'b010, $sformatf("rand_%0d", i), rnd_data[i]);
        end

        @(posedge clk);
        #3;
        reset = 1'b1;
        rd(rnd_addr[0], 3'b010, "midrst_a0", 32'h0);
        rd(rnd_addr[4], 3'b010, "midrst_a4", 32'h0);
        wr(32'h040, 32'hCAFEF00D, 3'b010, 1);
        check("rst_blocks_rd", 32'h0);
        #2;
        reset = 1'b0;
        rd(32'h040, 3'b010, "rst_blocked_wr", 32'h0);
        rd(rnd_addr[2], 3'b010, "post_rst_a2", 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
